// File: rtl/spm_seq_ctrl.sv
// Sequencing stage around one spm serial-parallel multiplier.
// Optional SPM_CTRL_ZERO_BYPASS_EN: zero operands skip the spm run.
module spm_seq_ctrl #(
  parameter int SIZE  = 32,
  parameter int P_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  output logic              spm_clr_n,
  input  logic              spm_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_prod
);

  localparam int L  = 2*SIZE + P_LAT;
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [SIZE-1:0]   b_sr;
  logic [2*SIZE-1:0] prod_sr;
  logic [2*SIZE-1:0] psh;
  logic              byp;
  logic              acc;
  logic              last;
  logic              samp;
  logic              zero;

  assign acc  = in_valid && in_ready;
  assign last = cnt == CW'(L - 1);
  assign samp = cnt >= CW'(P_LAT);
  assign psh  = {spm_p, prod_sr[2*SIZE-1:1]};

`ifdef SPM_CTRL_ZERO_BYPASS_EN
  assign zero = (in_a == '0) || (in_b == '0);
`else
  assign zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (acc) state_nx = zero ? DONE : RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    spm_clr_n = (state == RUN) ||
                (state == DONE && !byp);
    spm_y     = 1'b0;
    if (state == RUN && cnt < CW'(SIZE))
      spm_y = b_sr[0];
  end

  // Product bits arrive LSB-first, so they enter at the MSB and
  // settle into place after exactly 2*SIZE samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spm_x    <= '0;
      b_sr     <= '0;
      cnt      <= '0;
      prod_sr  <= '0;
      out_prod <= '0;
      byp      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            spm_x   <= in_a;
            b_sr    <= in_b;
            cnt     <= '0;
            prod_sr <= '0;
            byp     <= zero;
            if (zero) out_prod <= '0;
          end
        end
        RUN: begin
          cnt  <= cnt + 1'b1;
          b_sr <= b_sr >> 1;
          if (samp) prod_sr <= psh;
          if (last) out_prod <= psh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl with a behavioural spm (P_LAT=1).
// Vector table, hand sequences and random ops vs. a*b reference.
module tb_spm_seq_ctrl;

  localparam int SIZE  = 32;
  localparam int P_LAT = 1;
  localparam int LAT   = 2*SIZE + P_LAT + 1;
`ifdef SPM_CTRL_ZERO_BYPASS_EN
  localparam int ZLAT  = 1;
`else
  localparam int ZLAT  = LAT;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SIZE-1:0]   in_a = '0;
  logic [SIZE-1:0]   in_b = '0;
  logic [SIZE-1:0]   spm_x;
  logic              spm_y;
  logic              spm_clr_n;
  logic              spm_p;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*SIZE-1:0] out_prod;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spm_seq_ctrl #(.SIZE(SIZE), .P_LAT(P_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_clr_n (spm_clr_n),
    .spm_p     (spm_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  // Behavioural spm: collects y bits, emits bit j-1 of x*y at step j.
  int           sj;
  logic [63:0]  yv;
  logic [127:0] pm;

  always @(posedge clk) begin
    if (!spm_clr_n) begin
      sj <= 0;
      yv <= '0;
    end else begin
      if (sj < 64) yv[sj] <= spm_y;
      sj <= sj + 1;
    end
  end

  assign pm    = 128'(spm_x) * 128'(yv);
  assign spm_p = (spm_clr_n && sj >= 1 && sj <= 128) ? pm[sj-1] : 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          lat;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] ep, input int el,
                    input int hold, input bit pulse);
    int n;
    int lat;
    int xerr;
    int serr;
    logic [63:0] p;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(n < 200), 32'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    lat = 1;
    xerr = 0;
    while (!out_valid && lat < 300) begin
      if (spm_x !== a) xerr++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("x_hold", 32'(xerr), 32'd0);
    chk("prod", 128'(out_prod), 128'(ep));
    p = out_prod;
    serr = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse && (i == 3);
      @(posedge clk);
      #1;
      if (!out_valid || out_prod !== p || in_ready) serr++;
    end
    in_valid = 1'b0;
    if (hold > 0) chk("backpressure", 32'(serr), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release", {out_valid, in_ready, out_prod == p}, 3'b011);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    tv[0] = '{32'd3, 32'd5, 64'd15, LAT};
    tv[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, LAT};
    tv[2] = '{32'h80000000, 32'd2, 64'h100000000, LAT};
    tv[3] = '{32'd11, 32'd13, 64'd143, LAT};
    tv[4] = '{32'd1, 32'hFFFFFFFF, 64'hFFFFFFFF, LAT};
    tv[5] = '{32'h10000, 32'h10000, 64'h100000000, LAT};

    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_a = $urandom;
      in_b = $urandom;
      chk("rst_out", {out_valid, spm_clr_n, spm_y}, 3'b000);
    end
    chk("rst_prod", 128'(out_prod), 128'd0);
    chk("rst_x", 128'(spm_x), 128'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_state", {in_ready, out_valid, spm_clr_n, spm_y}, 4'b1000);
    chk("rel_prod", 128'(out_prod), 128'd0);

    for (int i = 0; i < 6; i++)
      op(tv[i].a, tv[i].b, tv[i].p, tv[i].lat, 0, 1'b0);

    // backpressure with an ignored in_valid pulse
    op(32'd1000, 32'd1000, 64'd1000000, LAT, 10, 1'b1);
    op(32'd6, 32'd7, 64'd42, LAT, 0, 1'b0);

    // reset at k=20 of RUN
    @(negedge clk);
    in_a = 32'd7;
    in_b = 32'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("mid_run", 32'(spm_clr_n), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ctl", {out_valid, spm_clr_n, spm_y}, 3'b000);
    chk("abort_x", 128'(spm_x), 128'd0);
    chk("abort_prod", 128'(out_prod), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    op(32'd11, 32'd13, 64'd143, LAT, 0, 1'b0);

    // zero operand
    op(32'd0, 32'h1234, 64'd0, ZLAT, 2, 1'b0);
    op(32'h1234, 32'd0, 64'd0, ZLAT, 0, 1'b0);

    // randomized ops against plain a*b
    for (int i = 0; i < 20; i++) begin
      ra = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      op(ra, rb, 64'(ra) * 64'(rb),
         (ra == 0 || rb == 0) ? ZLAT : LAT,
         int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
